// File: rtl/i2s_tx_fifo.sv
// Transmit sample FIFO between the APB control stage and the I2S serializer.
// Define I2S_TX_FIFO_FWFT_EN for first-word-fall-through rdata; default is registered 1-cycle-latency rdata.
module i2s_tx_fifo #(
    parameter int DW        = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     wen,
    input  logic [DW-1:0]            wdata,
    input  logic                     ren,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    // Status is decoded from the registered occupancy only, never from this cycle's requests.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_THRESH);
    assign almost_empty = (32'(count_q) <= AE_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = wen && !full;
        rd_acc      = ren && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event wins over a same-cycle clear so it is never lost.
        if (wen && full)  overflow_d = 1'b1;
        else if (clr_err) overflow_d = 1'b0;

        if (ren && empty) underflow_d = 1'b1;
        else if (clr_err) underflow_d = 1'b0;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not cleared on reset; the pointers make stale entries unreachable.
    always_ff @(posedge pclk) begin
        if (!preset && wr_acc) mem_q[wr_ptr_q] <= wdata;
    end

`ifdef I2S_TX_FIFO_FWFT_EN
    always_comb begin
        rdata = '0;
        if (!empty) rdata = mem_q[rd_ptr_q];
    end
`else
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) rdata_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge pclk) begin
        if (preset) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

endmodule
